flit_packetizer: RTL and testbench
==================================

Name: flit_packetizer

Overview:
- Network-interface injection stage that sits directly upstream of a router inport (e.g. the north inport).
- Takes a packet descriptor (destination X/Y, payload length) plus a payload word stream, and emits one head flit followed by payload body/tail flits on a 64-bit flit link.
- Obeys the router's on/off buffer_on flow control and stamps its own mesh coordinates as the source.

Parameters:
- X_SRC, 3'b000, X coordinate of this node, written into the head flit.
- Y_SRC, 3'b000, Y coordinate of this node, written into the head flit.
- MAX_LEN, 15, maximum payload flits per packet (pkt_len field is 4 bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  descriptor valid.
- pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready.
- pkt_dst_x  in  3  destination X.
- pkt_dst_y  in  3  destination Y.
- pkt_len  in  4  number of payload flits, 1..MAX_LEN.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word consumed when data_valid && data_ready.
- data_in  in  62  payload word.
- buffer_on_in  in  1  downstream inport on/off signal (1 = may send).
- flit_out  out  64  flit to the router inport flit_in.
- valid_out  out  1  flit_out valid, to the router inport valid_flit_in.
- err_len  out  1  one-cycle pulse when a descriptor with pkt_len == 0 is accepted.
- flits_sent  out  16  count of flits emitted; wraps.

Behaviour:
- Flit format:
  - [63:62] type: 01 head, 10 body, 11 tail, 00 never emitted.
  - Head payload: [61:59] dst_x, [58:56] dst_y, [55:53] X_SRC, [52:50] Y_SRC, [49:46] pkt_len, [45:0] zero.
  - Body/tail: [61:0] = data_in.
- Reset values: pkt_ready=0, data_ready=0, flit_out=0, valid_out=0, err_len=0, flits_sent=0; FSM in IDLE; latched descriptor and remaining-count cleared.
- FSM states and transitions:
  - IDLE: pkt_ready=1.
    - On accept with pkt_len != 0: latch dst/len, set remaining = pkt_len, go to HEAD.
    - On accept with pkt_len == 0: pulse err_len next cycle, emit nothing, stay in IDLE.
  - HEAD: pkt_ready=0, data_ready=0.
    - In a cycle with buffer_on_in=1, register the head flit: flit_out/valid_out=1 visible the next cycle. Go to PAYLOAD.
  - PAYLOAD: data_ready = buffer_on_in (combinational).
    - On a payload handshake, register a body flit (remaining>1) or tail flit (remaining==1) and decrement remaining.
    - After the tail, go to IDLE.
- Emission rules:
  - valid_out is registered. A flit appears exactly one cycle after the cycle in which buffer_on_in was sampled high and the flit was issued.
  - valid_out=0 in every other cycle; flit_out holds its last value when valid_out=0.
  - At most one flit per cycle.
  - Head-to-tail latency with continuous data and buffer_on_in=1: 1+pkt_len consecutive valid cycles.
- buffer_on_in low:
  - No new flit is issued. data_ready=0 and the FSM holds state/counters.
  - A flit already registered in the previous cycle is still presented; the router inport's on/off threshold absorbs this one-flit slack.
- data_valid low in PAYLOAD: no flit that cycle (bubble); valid_out=0 next cycle; resume when data returns. Bubbles inside a packet are legal (wormhole).
- Back-to-back packets: the tail is issued in cycle t; IDLE accepts the next descriptor at t+1; its head is issued at t+2 at the earliest.
- flits_sent increments by 1 on every cycle valid_out is 1; wraps 16'hFFFF -> 0.
- pkt_len > MAX_LEN (parameter < 15): clamp to MAX_LEN and pulse err_len.
- Reset mid-packet:
  - Next cycle all outputs return to reset values and the FSM returns to IDLE.
  - The partial packet is abandoned; no tail is generated.
  - The downstream router is reset together with this block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, pkt_ready=1 in the first cycle after rst drops.
- Single packet, dst=(3,2), len=3, X_SRC=1, Y_SRC=0, buffer_on_in=1, data A,B,C continuous -> 4 consecutive valid flits:
  - Head = {2'b01,3'd3,3'd2,3'd1,3'd0,4'd3,46'b0}.
  - Then {10,A}, {10,B}, {11,C}.
  - flits_sent=4.
- Backpressure: same packet, buffer_on_in=0 for 3 cycles after the head is issued -> exactly one further flit at most during the off window; data_ready=0; resumes and completes with no dropped or duplicated payload.
- Payload bubbles: data_valid toggles 1,0,1,0 with len=2 -> head, gap, body, gap, tail; types correct.
- Zero length and back-to-back:
  - pkt_len=0 -> err_len pulses once, no valid_out.
  - Then two len=1 packets back-to-back -> head,tail,(1 idle),head,tail.
- Reset mid-packet and counter wrap:
  - rst asserted after the head of a len=5 packet -> valid_out=0 next cycle, FSM IDLE, no tail.
  - Preload via 65536 flits -> flits_sent wraps to 0.

Source files
------------

// File: rtl/flit_packetizer.sv
// flit_packetizer: network-interface injection stage in front of a router inport.
// Accepts a packet descriptor (dst X/Y, payload length) and a payload word
// stream, and emits one head flit followed by body/tail flits on a 64-bit
// flit link under the router's on/off (buffer_on_in) flow control.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pkt_valid/pkt_ready descriptor handshake; pkt_dst_x/pkt_dst_y/pkt_len fields
//   data_valid/data_ready/data_in  payload word handshake (62-bit words)
//   buffer_on_in        downstream on/off (1 = may send)
//   flit_out/valid_out  registered flit link to the router inport
//   err_len             one-cycle pulse on a zero or over-long descriptor
//   flits_sent          wrapping count of emitted flits
module flit_packetizer #(
  parameter logic [2:0]  X_SRC   = 3'b000,
  parameter logic [2:0]  Y_SRC   = 3'b000,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [2:0]  pkt_dst_x,
  input  logic [2:0]  pkt_dst_y,
  input  logic [3:0]  pkt_len,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [61:0] data_in,
  input  logic        buffer_on_in,
  output logic [63:0] flit_out,
  output logic        valid_out,
  output logic        err_len,
  output logic [15:0] flits_sent
);

  localparam int unsigned FLIT_W  = 64;
  localparam int unsigned DATA_W  = 62;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PAD_W   = FLIT_W - 2 - 4 * COORD_W - LEN_W;

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_PAYLOAD
  } state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   dst_x_q, dst_x_d;
  logic [COORD_W-1:0]   dst_y_q, dst_y_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [FLIT_W-1:0]    flit_q, flit_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pkt_accept;
  logic                 data_hs;
  logic                 len_over;
  logic [LEN_W-1:0]     len_eff;

  // Handshake readies are combinational so back-to-back transfers need no bubble.
  assign pkt_ready  = (state_q == S_IDLE) && !rst;
  assign data_ready = (state_q == S_PAYLOAD) && buffer_on_in && !rst;

  assign pkt_accept = pkt_valid && pkt_ready;
  assign data_hs    = data_valid && data_ready;

  // Compare one bit wider so the check stays meaningful when MAX_LEN is 15.
  assign len_over = {1'b0, pkt_len} > 5'(MAX_LEN);
  assign len_eff  = len_over ? MAX_LEN_L : pkt_len;

  // Next-state and flit issue logic.
  always_comb begin
    state_d = state_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    len_d   = len_q;
    rem_d   = rem_q;
    flit_d  = flit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pkt_accept) begin
          if (pkt_len == '0) begin
            err_d = 1'b1;
          end else begin
            dst_x_d = pkt_dst_x;
            dst_y_d = pkt_dst_y;
            len_d   = len_eff;
            rem_d   = len_eff;
            err_d   = len_over;
            state_d = S_HEAD;
          end
        end
      end
      S_HEAD: begin
        if (buffer_on_in) begin
          flit_d  = {TYPE_HEAD, dst_x_q, dst_y_q, X_SRC, Y_SRC, len_q, {PAD_W{1'b0}}};
          valid_d = 1'b1;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (data_hs) begin
          flit_d  = {(rem_q == LEN_W'(1)) ? TYPE_TAIL : TYPE_BODY, data_in[DATA_W-1:0]};
          valid_d = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter advances together with the flit it counts.
  assign cnt_d = cnt_q + CNT_W'(valid_d);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dst_x_q <= '0;
      dst_y_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flit_out   = flit_q;
  assign valid_out  = valid_q;
  assign err_len    = err_q;
  assign flits_sent = cnt_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Scoreboard bench for flit_packetizer: the driver pushes expected flits as it
// issues descriptors and payload words; a negedge monitor pops and compares.
module tb_flit_packetizer;

  localparam logic [2:0] XS = 3'd1;
  localparam logic [2:0] YS = 3'd0;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_dst_x;
  logic [2:0]  pkt_dst_y;
  logic [3:0]  pkt_len;
  logic        data_valid;
  logic        data_ready;
  logic [61:0] data_in;
  logic        buffer_on_in;
  logic [63:0] flit_out;
  logic        valid_out;
  logic        err_len;
  logic [15:0] flits_sent;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  int          vtimes[$];
  logic [15:0] exp_sent;

  flit_packetizer #(.X_SRC(XS), .Y_SRC(YS), .MAX_LEN(15)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dst_x(pkt_dst_x), .pkt_dst_y(pkt_dst_y), .pkt_len(pkt_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .buffer_on_in(buffer_on_in),
    .flit_out(flit_out), .valid_out(valid_out),
    .err_len(err_len), .flits_sent(flits_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every valid flit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (valid_out) begin
      vtimes.push_back(cyc);
      if (exp_q.size() == 0) chk("unexp_flit", 64'(exp_q.size()), 64'd1);
      else chk("flit", flit_out, exp_q.pop_front());
    end
  end

  // Called and returns at posedge+1; presents a descriptor until accepted.
  task automatic send_desc(input logic [2:0] dx, input logic [2:0] dy, input logic [3:0] len);
    logic acc;
    logic done;
    done = 1'b0;
    pkt_valid = 1'b1; pkt_dst_x = dx; pkt_dst_y = dy; pkt_len = len;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk); acc = pkt_ready;
      @(posedge clk); #1;
      if (acc) begin done = 1'b1; break; end
    end
    pkt_valid = 1'b0;
    if (!done) chk("tmo_desc", 64'(done), 64'd1);
  endtask

  task automatic send_pkt(input logic [2:0] dx, input logic [2:0] dy, input logic [3:0] len,
                          input logic bubble);
    logic [61:0] w;
    logic        r;
    logic        done;
    send_desc(dx, dy, len);
    if (len == 4'd0) return;
    exp_q.push_back({2'b01, dx, dy, XS, YS, len, 46'd0});
    exp_sent = exp_sent + 16'(len) + 16'd1;
    for (int k = 0; k < int'(len); k++) begin
      w = 62'({$urandom(), $urandom()});
      exp_q.push_back({(k == int'(len) - 1) ? 2'b11 : 2'b10, w});
      if (bubble) begin
        // Idle for one cycle in which the DUT could have taken data.
        for (int t = 0; t < TMO; t++) begin
          @(negedge clk); r = data_ready;
          @(posedge clk); #1;
          if (r) break;
        end
      end
      data_valid = 1'b1; data_in = w;
      done = 1'b0;
      for (int t = 0; t < TMO; t++) begin
        @(negedge clk); r = data_ready;
        @(posedge clk); #1;
        if (r) begin done = 1'b1; break; end
      end
      data_valid = 1'b0;
      if (!done) chk("tmo_data", 64'(done), 64'd1);
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_sent"}, 64'(flits_sent), 64'(exp_sent));
  endtask

  initial begin
    logic done;
    int   vw;
    rst = 1'b1; pkt_valid = 1'b0; pkt_dst_x = '0; pkt_dst_y = '0; pkt_len = '0;
    data_valid = 1'b0; data_in = '0; buffer_on_in = 1'b1; exp_sent = '0;

    // Reset values
    @(posedge clk); @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_flit", flit_out, 64'd0);
    chk("rst_err", 64'(err_len), 64'd0);
    chk("rst_cnt", 64'(flits_sent), 64'd0);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_pkt_ready", 64'(pkt_ready), 64'd1);
    @(posedge clk); #1;

    // Single packet, continuous data
    vtimes.delete();
    send_pkt(3'd3, 3'd2, 4'd3, 1'b0);
    drain("single");
    chk("single_cnt", 64'(flits_sent), 64'd4);
    chk("single_nflits", 64'(vtimes.size()), 64'd4);
    chk("single_span", 64'(vtimes[3] - vtimes[0]), 64'd3);

    // Backpressure for 3 cycles after the head appears
    vw = 0;
    fork
      send_pkt(3'd3, 3'd2, 4'd3, 1'b0);
      begin
        done = 1'b0;
        for (int t = 0; t < TMO; t++) begin
          @(negedge clk);
          if (valid_out && flit_out[63:62] == 2'b01) begin done = 1'b1; break; end
        end
        chk("bp_head_seen", 64'(done), 64'd1);
        @(posedge clk); #1 buffer_on_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_data_ready", 64'(data_ready), 64'd0);
          vw += int'(valid_out);
          if (i < 2) @(posedge clk);
        end
        @(posedge clk); #1 buffer_on_in = 1'b1;
      end
    join
    chk("bp_window", 64'(vw), 64'd1);
    drain("bp");

    // Payload bubbles
    vtimes.delete();
    send_pkt(3'd5, 3'd6, 4'd2, 1'b1);
    drain("bub");
    chk("bub_nflits", 64'(vtimes.size()), 64'd3);
    chk("bub_gap1", 64'(vtimes[1] - vtimes[0]), 64'd2);
    chk("bub_gap2", 64'(vtimes[2] - vtimes[1]), 64'd2);

    // Zero length
    send_pkt(3'd1, 3'd1, 4'd0, 1'b0);
    @(negedge clk);
    chk("zero_err", 64'(err_len), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_err_off", 64'(err_len), 64'd0);
    chk("zero_no_valid", 64'(valid_out), 64'd0);
    @(posedge clk); #1;

    // Back-to-back single-word packets
    vtimes.delete();
    send_pkt(3'd2, 3'd2, 4'd1, 1'b0);
    send_pkt(3'd4, 3'd4, 4'd1, 1'b0);
    drain("b2b");
    chk("b2b_nflits", 64'(vtimes.size()), 64'd4);
    chk("b2b_gap1", 64'(vtimes[1] - vtimes[0]), 64'd1);
    chk("b2b_gap2", 64'(vtimes[2] - vtimes[1]), 64'd2);
    chk("b2b_gap3", 64'(vtimes[3] - vtimes[2]), 64'd1);

    // Reset right after the head of a len=5 packet
    send_desc(3'd7, 3'd7, 4'd5);
    exp_q.push_back({2'b01, 3'd7, 3'd7, XS, YS, 4'd5, 46'd0});
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_head", 64'(valid_out), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_sent = '0;
    @(negedge clk);
    chk("mid_valid", 64'(valid_out), 64'd0);
    chk("mid_flit", flit_out, 64'd0);
    chk("mid_cnt", 64'(flits_sent), 64'd0);
    chk("mid_idle", 64'(pkt_ready), 64'd1);
    @(posedge clk); #1;
    data_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 data_valid = 1'b0;
    drain("mid");

    // Counter wrap: 4096 packets of 16 flits
    for (int i = 0; i < 4096; i++) send_pkt(3'(i), 3'(i >> 3), 4'd15, 1'b0);
    drain("wrap");
    chk("wrap_zero", 64'(flits_sent), 64'd0);
    send_pkt(3'd0, 3'd7, 4'd1, 1'b0);
    drain("post_wrap");
    chk("post_wrap_cnt", 64'(flits_sent), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
